// File: rtl/watchdog_rf_sequencer.sv
// watchdog_rf_sequencer
// Owns the watchdog timer controls and the RF enable/gain of the AM transmitter.
// Combines the masked per-source heartbeats into one watchdog heartbeat. Ramps
// the RF gain up when armed, and ramps it down on disarm or on a watchdog trip.
// A trip latches a fault until the host clears it and a cooldown elapses.
// Every output comes from a register. Output decode uses the next state, so
// each output matches the state shown on state_o in the same cycle.
module watchdog_rf_sequencer #(
  parameter int NUM_SRC      = 4,
  parameter int GAIN_W       = 8,
  parameter int GAIN_MAX     = 255,
  parameter int RAMP_STEP    = 32,
  parameter int COOLDOWN_CYC = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               arm,
  input  logic               disarm,
  input  logic               clear_fault,
  input  logic [NUM_SRC-1:0] src_mask,
  input  logic [NUM_SRC-1:0] src_beat,
  input  logic               wd_warning,
  input  logic               wd_triggered,
  output logic               wd_enable,
  output logic               wd_force_reset,
  output logic               wd_heartbeat,
  output logic               rf_enable,
  output logic [GAIN_W-1:0]  rf_gain,
  output logic               fault,
  output logic               warn,
  output logic [2:0]         state_o
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARMING    = 3'd1,
    ST_RAMP_UP   = 3'd2,
    ST_RUN       = 3'd3,
    ST_RAMP_DOWN = 3'd4,
    ST_FAULT     = 3'd5,
    ST_COOLDOWN  = 3'd6
  } state_e;

  localparam logic [GAIN_W:0]   STEP_X = (GAIN_W+1)'(RAMP_STEP);
  localparam logic [GAIN_W:0]   MAX_X  = (GAIN_W+1)'(GAIN_MAX);
  localparam logic [GAIN_W-1:0] MAX_G  = GAIN_W'(GAIN_MAX);
  localparam int                CNT_W  = (COOLDOWN_CYC > 1) ? $clog2(COOLDOWN_CYC) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(COOLDOWN_CYC - 1);

  // Saturating ramp-up step. The sum is one bit wider, so it cannot wrap before the clamp.
  function automatic logic [GAIN_W-1:0] ramp_up_f(input logic [GAIN_W-1:0] g);
    logic [GAIN_W:0] sum;
    sum = {1'b0, g} + STEP_X;
    if (sum >= MAX_X) begin
      ramp_up_f = MAX_G;
    end else begin
      ramp_up_f = sum[GAIN_W-1:0];
    end
  endfunction

  // Ramp-down step that stops at zero instead of underflowing.
  function automatic logic [GAIN_W-1:0] ramp_down_f(input logic [GAIN_W-1:0] g);
    if ({1'b0, g} > STEP_X) begin
      ramp_down_f = g - STEP_X[GAIN_W-1:0];
    end else begin
      ramp_down_f = '0;
    end
  endfunction

  // Heartbeat aggregation runs only while the transmitter ramps up or runs.
  function automatic logic hb_state_f(input state_e s);
    hb_state_f = (s == ST_RAMP_UP) || (s == ST_RUN);
  endfunction

  state_e              state_q, state_d;
  logic [GAIN_W-1:0]   gain_q, gain_d;
  logic                trip_q, trip_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_SRC-1:0]  seen_q, seen_d;
  logic [NUM_SRC-1:0]  mask_q;
  logic                wd_enable_q, wd_enable_d;
  logic                wd_force_reset_q, wd_force_reset_d;
  logic                wd_heartbeat_q, wd_heartbeat_d;
  logic                rf_enable_q, rf_enable_d;
  logic                fault_q, fault_d;
  logic                warn_q, warn_d;
  logic [GAIN_W-1:0]   gain_up_s, gain_dn_s;
  logic [NUM_SRC-1:0]  seen_next_s;
  logic                hb_active_s;

  assign gain_up_s = ramp_up_f(gain_q);
  assign gain_dn_s = ramp_down_f(gain_q);

  // Sequencer: next state, gain ramp, trip flag and cooldown counter.
  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    trip_d  = trip_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        gain_d = '0;
        trip_d = 1'b0;
        cnt_d  = '0;
        if (arm && !disarm && (src_mask != '0)) begin
          state_d = ST_ARMING;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARMING: begin
        gain_d  = gain_up_s;
        state_d = ST_RAMP_UP;
      end
      ST_RAMP_UP, ST_RUN: begin
        if (wd_triggered) begin
          // A trip beats a disarm that arrives in the same cycle.
          state_d = ST_RAMP_DOWN;
          trip_d  = 1'b1;
          gain_d  = gain_dn_s;
        end else if (disarm) begin
          state_d = ST_RAMP_DOWN;
          trip_d  = 1'b0;
          gain_d  = gain_dn_s;
        end else if (state_q == ST_RUN) begin
          state_d = ST_RUN;
          gain_d  = MAX_G;
        end else begin
          gain_d = gain_up_s;
          if (gain_up_s == MAX_G) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_RAMP_UP;
          end
        end
      end
      ST_RAMP_DOWN: begin
        // A trip during a disarm ramp turns it into a fault ramp.
        trip_d = trip_q | wd_triggered;
        if (gain_q == '0) begin
          gain_d = '0;
          if (trip_q || wd_triggered) begin
            state_d = ST_FAULT;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          gain_d  = gain_dn_s;
          state_d = ST_RAMP_DOWN;
        end
      end
      ST_FAULT: begin
        gain_d = '0;
        trip_d = 1'b0;
        cnt_d  = '0;
        if (clear_fault) begin
          state_d = ST_COOLDOWN;
        end else begin
          state_d = ST_FAULT;
        end
      end
      ST_COOLDOWN: begin
        gain_d = '0;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = ST_COOLDOWN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gain_d  = '0;
        trip_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // Heartbeat aggregation: pulse once every masked source has beaten, then start over.
  always_comb begin
    seen_next_s    = seen_q | (src_beat & src_mask);
    hb_active_s    = hb_state_f(state_q) && hb_state_f(state_d);
    seen_d         = '0;
    wd_heartbeat_d = 1'b0;
    if (!hb_active_s) begin
      seen_d         = '0;
      wd_heartbeat_d = 1'b0;
    end else if (src_mask != mask_q) begin
      // Progress toward the old mask does not count toward a new one.
      seen_d         = '0;
      wd_heartbeat_d = 1'b0;
    end else if ((seen_next_s == src_mask) && (src_mask != '0)) begin
      // Beats that complete the set are used up here and not carried into the next round.
      seen_d         = '0;
      wd_heartbeat_d = 1'b1;
    end else begin
      seen_d         = seen_next_s;
      wd_heartbeat_d = 1'b0;
    end
  end

  // Output decode from the next state, so each registered output lines up with its state.
  always_comb begin
    wd_enable_d      = 1'b0;
    wd_force_reset_d = 1'b0;
    rf_enable_d      = 1'b0;
    fault_d          = 1'b0;
    warn_d           = 1'b0;
    case (state_d)
      ST_IDLE: begin
        wd_enable_d = 1'b0;
      end
      ST_ARMING: begin
        wd_enable_d      = 1'b1;
        wd_force_reset_d = 1'b1;
      end
      ST_RAMP_UP: begin
        wd_enable_d = 1'b1;
        rf_enable_d = 1'b1;
      end
      ST_RUN: begin
        wd_enable_d = 1'b1;
        rf_enable_d = 1'b1;
        warn_d      = wd_warning;
      end
      ST_RAMP_DOWN: begin
        rf_enable_d = (gain_d != '0);
      end
      ST_FAULT, ST_COOLDOWN: begin
        fault_d = 1'b1;
      end
      default: begin
        wd_enable_d = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers; asynchronous reset clears everything.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q          <= ST_IDLE;
      gain_q           <= '0;
      trip_q           <= 1'b0;
      cnt_q            <= '0;
      seen_q           <= '0;
      mask_q           <= '0;
      wd_enable_q      <= 1'b0;
      wd_force_reset_q <= 1'b0;
      wd_heartbeat_q   <= 1'b0;
      rf_enable_q      <= 1'b0;
      fault_q          <= 1'b0;
      warn_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      gain_q           <= gain_d;
      trip_q           <= trip_d;
      cnt_q            <= cnt_d;
      seen_q           <= seen_d;
      mask_q           <= src_mask;
      wd_enable_q      <= wd_enable_d;
      wd_force_reset_q <= wd_force_reset_d;
      wd_heartbeat_q   <= wd_heartbeat_d;
      rf_enable_q      <= rf_enable_d;
      fault_q          <= fault_d;
      warn_q           <= warn_d;
    end
  end

  assign wd_enable      = wd_enable_q;
  assign wd_force_reset = wd_force_reset_q;
  assign wd_heartbeat   = wd_heartbeat_q;
  assign rf_enable      = rf_enable_q;
  assign rf_gain        = gain_q;
  assign fault          = fault_q;
  assign warn           = warn_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_watchdog_rf_sequencer.sv
// Testbench for watchdog_rf_sequencer.
// The stimulus process pushes one hand-computed output vector for each clock.
// A monitor pops that vector after the clock edge and compares it.
module tb_watchdog_rf_sequencer;

  logic       clk, rstn;
  logic       arm, disarm, clear_fault, wd_warning, wd_triggered;
  logic [3:0] src_mask, src_beat;
  logic       wd_enable, wd_force_reset, wd_heartbeat, rf_enable, fault, warn;
  logic [7:0] rf_gain;
  logic [2:0] state_o;
  logic [16:0] act_s;

  int checks = 0;
  int errors = 0;

  logic [16:0] exp_q[$];
  string       lbl_q[$];

  logic [7:0] up_tbl [0:6] = '{8'd32, 8'd64, 8'd96, 8'd128, 8'd160, 8'd192, 8'd224};
  logic [7:0] dn_tbl [0:7] = '{8'd223, 8'd191, 8'd159, 8'd127, 8'd95, 8'd63, 8'd31, 8'd0};

  watchdog_rf_sequencer #(
    .NUM_SRC(4), .GAIN_W(8), .GAIN_MAX(255), .RAMP_STEP(32), .COOLDOWN_CYC(16)
  ) dut (
    .clk(clk), .rstn(rstn), .arm(arm), .disarm(disarm), .clear_fault(clear_fault),
    .src_mask(src_mask), .src_beat(src_beat), .wd_warning(wd_warning),
    .wd_triggered(wd_triggered), .wd_enable(wd_enable), .wd_force_reset(wd_force_reset),
    .wd_heartbeat(wd_heartbeat), .rf_enable(rf_enable), .rf_gain(rf_gain),
    .fault(fault), .warn(warn), .state_o(state_o)
  );

  assign act_s = {state_o, wd_enable, wd_force_reset, wd_heartbeat, rf_enable, rf_gain, fault, warn};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit layout: {state[2:0], wd_en, wd_force_reset, wd_hb, rf_en, gain[7:0], fault, warn}.
  function automatic logic [16:0] ev(input logic [2:0] st, input logic wen, input logic wfr,
                                     input logic hb, input logic ren, input logic [7:0] g,
                                     input logic flt, input logic wrn);
    ev = {st, wen, wfr, hb, ren, g, flt, wrn};
  endfunction

  // Queue the expected outputs for the coming edge, then move to the next falling edge.
  task automatic tick(input string lbl, input logic [16:0] e);
    exp_q.push_back(e);
    lbl_q.push_back(lbl);
    @(negedge clk);
  endtask

  // Compare outputs right away, with no clock edge involved (used for reset checks).
  task automatic check_now(input string lbl, input logic [16:0] e);
    checks++;
    if (act_s !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", lbl, act_s, e);
    end
  endtask

  // Monitor: pop and compare one expected vector shortly after each rising edge.
  always @(posedge clk) begin
    logic [16:0] e;
    string l;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      l = lbl_q.pop_front();
      checks++;
      if (act_s !== e) begin
        errors++;
        $display("FAIL %s: got %h expected %h (state %0d gain %0d)", l, act_s, e, state_o, rf_gain);
      end
    end
  end

  // Arm from IDLE with the current mask: ARMING, seven RAMP_UP steps, then RUN at 255.
  task automatic arm_seq();
    arm = 1'b1;
    tick("arming", ev(3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0));
    for (int i = 0; i < 7; i++) begin
      tick("ramp_up", ev(3'd2, 1'b1, 1'b0, 1'b0, 1'b1, up_tbl[i], 1'b0, 1'b0));
    end
    tick("run_entry", ev(3'd3, 1'b1, 1'b0, 1'b0, 1'b1, 8'd255, 1'b0, 1'b0));
  endtask

  // Ramp down from RUN. Trip and disarm are each driven on one chosen step (-1 means never).
  task automatic rd_seq(input int trig_tick, input int dis_tick, input logic to_fault);
    for (int i = 0; i < 8; i++) begin
      wd_triggered = (i == trig_tick);
      disarm       = (i == dis_tick);
      tick("ramp_down", ev(3'd4, 1'b0, 1'b0, 1'b0, (i < 7), dn_tbl[i], 1'b0, 1'b0));
    end
    wd_triggered = 1'b0;
    disarm       = 1'b0;
    if (to_fault) begin
      tick("fault_entry", ev(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0));
    end else begin
      tick("idle_after_disarm", ev(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0));
    end
  endtask

  // Clear the fault, spend 16 cycles in COOLDOWN, then return to IDLE.
  task automatic cool_seq();
    arm         = 1'b0;
    clear_fault = 1'b1;
    tick("cooldown", ev(3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0));
    clear_fault = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick("cooldown", ev(3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0));
    end
    tick("cooldown_exit", ev(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0));
  endtask

  // Global time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

  // Directed stimulus.
  initial begin
    arm = 1'b0; disarm = 1'b0; clear_fault = 1'b0; wd_warning = 1'b0; wd_triggered = 1'b0;
    src_mask = 4'b0000; src_beat = 4'b0000;
    rstn = 1'b1;
    #1 rstn = 1'b0;
    #2 check_now("reset_outputs", 17'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    tick("idle_after_reset", ev(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0));

    // Arm, ramp up and run with sources 0 and 1 required.
    src_mask = 4'b0011;
    arm_seq();
    src_beat = 4'b0001; tick("hb_src0", ev(3'd3, 1'b1, 1'b0, 1'b0, 1'b1, 8'd255, 1'b0, 1'b0));
    src_beat = 4'b0000; tick("hb_gap", ev(3'd3, 1'b1, 1'b0, 1'b0, 1'b1, 8'd255, 1'b0, 1'b0));
    src_beat = 4'b0010; tick("hb_pulse", ev(3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 8'd255, 1'b0, 1'b0));
    src_beat = 4'b0000; tick("hb_single", ev(3'd3, 1'b1, 1'b0, 1'b0, 1'b1, 8'd255, 1'b0, 1'b0));
    src_beat = 4'b1100; tick("hb_unmasked", ev(3'd3, 1'b1, 1'b0, 1'b0, 1'b1, 8'd255, 1'b0, 1'b0));
    src_beat = 4'b0000; tick("hb_unmasked2", ev(3'd3, 1'b1, 1'b0, 1'b0, 1'b1, 8'd255, 1'b0, 1'b0));
    // A mask change discards sources already seen.
    src_beat = 4'b0001; tick("hb_pre_mask", ev(3'd3, 1'b1, 1'b0, 1'b0, 1'b1, 8'd255, 1'b0, 1'b0));
    src_beat = 4'b0000; src_mask = 4'b0111;
    tick("hb_mask_chg", ev(3'd3, 1'b1, 1'b0, 1'b0, 1'b1, 8'd255, 1'b0, 1'b0));
    src_beat = 4'b0110; tick("hb_after_mask", ev(3'd3, 1'b1, 1'b0, 1'b0, 1'b1, 8'd255, 1'b0, 1'b0));
    src_beat = 4'b0001; tick("hb_mask_full", ev(3'd3, 1'b1, 1'b0, 1'b1, 1'b1, 8'd255, 1'b0, 1'b0));
    src_beat = 4'b0000; src_mask = 4'b0011;
    tick("hb_mask_back", ev(3'd3, 1'b1, 1'b0, 1'b0, 1'b1, 8'd255, 1'b0, 1'b0));
    // The warning is passed through while in RUN.
    wd_warning = 1'b1; tick("warn_run", ev(3'd3, 1'b1, 1'b0, 1'b0, 1'b1, 8'd255, 1'b0, 1'b1));
    wd_warning = 1'b0; tick("warn_clear", ev(3'd3, 1'b1, 1'b0, 1'b0, 1'b1, 8'd255, 1'b0, 1'b0));
    // Watchdog trip ends in FAULT; a held arm is ignored there.
    rd_seq(0, -1, 1'b1);
    tick("fault_hold_arm", ev(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0));
    cool_seq();
    wd_warning = 1'b1; tick("warn_idle", ev(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0));
    wd_warning = 1'b0;

    // Dropping arm alone keeps RUN; a disarm returns to IDLE without a fault.
    arm_seq();
    arm = 1'b0; tick("arm_drop_run", ev(3'd3, 1'b1, 1'b0, 1'b0, 1'b1, 8'd255, 1'b0, 1'b0));
    rd_seq(-1, 0, 1'b0);
    tick("idle_stays", ev(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0));

    // Disarm and trip in the same cycle: the trip wins.
    arm_seq();
    arm = 1'b0;
    rd_seq(0, 0, 1'b1);
    cool_seq();

    // A trip during a disarm ramp turns it into a fault.
    arm_seq();
    arm = 1'b0;
    rd_seq(1, 0, 1'b1);
    cool_seq();

    // Arming with an empty mask is refused.
    src_mask = 4'b0000; arm = 1'b1;
    tick("mask0_idle", ev(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0));
    tick("mask0_idle2", ev(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0));
    arm = 1'b0; src_mask = 4'b0011;
    tick("idle_pre_rst", ev(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0));

    // Asynchronous reset in the middle of the ramp, at gain 96.
    arm = 1'b1;
    tick("arming_rst", ev(3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++) begin
      tick("ramp_up_rst", ev(3'd2, 1'b1, 1'b0, 1'b0, 1'b1, up_tbl[i], 1'b0, 1'b0));
    end
    #2 rstn = 1'b0;
    #1 check_now("async_reset", 17'd0);
    @(negedge clk);
    arm = 1'b0;
    rstn = 1'b1;
    tick("idle_after_async", ev(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0));

    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected vectors left unchecked, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
